// File: rtl/scale_mem_pkg.sv
// Op codes, FSM state encodings and frame-centring helpers for the scale/memory sequencer.
// Shared by the sequencer top and its benches.
package scale_mem_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_RD      = 3'd1;
  localparam logic [2:0] OP_WR      = 3'd2;
  localparam logic [2:0] OP_NN_UP   = 3'd3;
  localparam logic [2:0] OP_NN_DOWN = 3'd4;
  localparam logic [2:0] OP_BLK_AVG = 3'd5;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_WAIT  = 3'd2;
  localparam logic [2:0] ST_WR_ISSUE = 3'd3;
  localparam logic [2:0] ST_NEXT     = 3'd4;
  localparam logic [2:0] ST_FINISH   = 3'd5;

  // Left/top margin that centres a frame shrunk by 2^s inside the full frame.
  function automatic int x0_off(input int img_w, input logic [1:0] s);
    return (img_w - (img_w >> s)) / 2;
  endfunction

  function automatic int y0_off(input int img_h, input logic [1:0] s);
    return (img_h - (img_h >> s)) / 2;
  endfunction

endpackage

// File: rtl/pixel_coord_gen.sv
// Raster x/y counter over a width x height region with wrap and last-pixel flag.
// Advances one position per step; clear returns to (0,0).
module pixel_coord_gen #(
  parameter int CW = 9
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          step,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] height,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == width - CW'(1));
  assign y_end = (y == height - CW'(1));
  assign last  = x_end && y_end;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + CW'(1);
      end else begin
        x <= x + CW'(1);
      end
    end
  end

endmodule

// File: rtl/scale_mem_sequencer.sv
// Single-port memory sequencer: single RD/WR plus nearest-neighbour zoom, decimation and block average.
// Single ops finish in 1 or RD_LAT+1 cycles; starts while busy are ignored, no memory backpressure.
module scale_mem_sequencer
  import scale_mem_pkg::*;
#(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 2,
  parameter int SRC_BASE = 19200,
  parameter int DST_BASE = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [1:0]        scale,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW    = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);
  localparam int SW    = $clog2(IMG_W * IMG_H + 1);
  localparam int ACC_W = DATA_W + 4;
  localparam logic [SW-1:0] LAST_FULL = SW'(IMG_W * IMG_H - 1);
  localparam logic [SW-1:0] LAST_S1   = SW'((IMG_W >> 1) * (IMG_H >> 1) - 1);
  localparam logic [SW-1:0] LAST_S2   = SW'((IMG_W >> 2) * (IMG_H >> 2) - 1);

  logic [2:0]        state;
  logic [2:0]        op_q;
  logic [1:0]        scale_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        wait_cnt;
  logic [ACC_W-1:0]  acc;
  logic [SW-1:0]     step_cnt;
  logic              done_q;
  logic              err_q;

  logic [CW-1:0]     reg_w, reg_h, dst_x, dst_y;
  logic [2:0]        blk_n, blk_x, blk_y;
  logic              dst_last, blk_last;
  logic              wait_last, frame_end;
  logic [SW-1:0]     last_step;
  logic [ACC_W-1:0]  acc_sum;
  logic [2:0]        avg_sh;
  logic [DATA_W-1:0] avg_val;
  int                x0, y0, sx, sy, wx, wy;

  function automatic logic [ADDR_W-1:0] pix_addr(input int base, input int x, input int y);
    return ADDR_W'(base + y * IMG_W + x);
  endfunction

  assign busy      = (state != ST_IDLE);
  assign done      = done_q || (state == ST_FINISH);
  assign err       = err_q;
  assign mem_we    = (state == ST_WR_ISSUE);
  assign mem_wdata = wdata_q;
  assign rdata_out = rdata_q;

  assign wait_last = (wait_cnt == 3'(RD_LAT - 1));
  assign blk_n     = (op_q == OP_BLK_AVG) ? (3'd1 << scale_q) : 3'd1;
  assign last_step = (op_q == OP_NN_UP) ? LAST_FULL : ((scale_q == 2'd2) ? LAST_S2 : LAST_S1);
  // The step counter is the terminator; the raster flag must agree with it.
  assign frame_end = dst_last && (step_cnt == last_step);

  // Averaging shift is 2s for BLK_AVG and zero for the single-sample NN ops.
  assign acc_sum = acc + ACC_W'(mem_rdata);
  assign avg_sh  = (op_q == OP_BLK_AVG) ? {scale_q, 1'b0} : 3'd0;
  assign avg_val = DATA_W'(acc_sum >> avg_sh);

  always_comb begin
    reg_w = CW'(IMG_W);
    reg_h = CW'(IMG_H);
    if (op_q != OP_NN_UP) begin
      reg_w = CW'(IMG_W >> scale_q);
      reg_h = CW'(IMG_H >> scale_q);
    end
  end

  always_comb begin
    x0 = x0_off(IMG_W, scale_q);
    y0 = y0_off(IMG_H, scale_q);
    if (op_q == OP_NN_UP) begin
      sx = x0 + (int'(dst_x) >> scale_q);
      sy = y0 + (int'(dst_y) >> scale_q);
      wx = int'(dst_x);
      wy = int'(dst_y);
    end else begin
      sx = (int'(dst_x) << scale_q) + int'(blk_x);
      sy = (int'(dst_y) << scale_q) + int'(blk_y);
      wx = x0 + int'(dst_x);
      wy = y0 + int'(dst_y);
    end
  end

  always_comb begin
    case (state)
      ST_RD_ISSUE, ST_RD_WAIT: mem_addr = (op_q == OP_RD) ? addr_q : pix_addr(SRC_BASE, sx, sy);
      ST_WR_ISSUE:             mem_addr = (op_q == OP_WR) ? addr_q : pix_addr(DST_BASE, wx, wy);
      default:                 mem_addr = '0;
    endcase
  end

  pixel_coord_gen #(.CW(CW)) u_dst (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == ST_IDLE),
    .step    (state == ST_NEXT),
    .width   (reg_w),
    .height  (reg_h),
    .x       (dst_x),
    .y       (dst_y),
    .last    (dst_last)
  );

  pixel_coord_gen #(.CW(3)) u_blk (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == ST_IDLE),
    .step    ((state == ST_RD_WAIT) && wait_last && (op_q != OP_RD)),
    .width   (blk_n),
    .height  (blk_n),
    .x       (blk_x),
    .y       (blk_y),
    .last    (blk_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      scale_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
      acc      <= '0;
      step_cnt <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          op_q     <= op;
          scale_q  <= scale;
          addr_q   <= addr_in;
          wdata_q  <= wdata_in;
          acc      <= '0;
          step_cnt <= '0;
          if (op > OP_BLK_AVG || (op >= OP_NN_UP && (scale == 2'd0 || scale == 2'd3)))
            err_q <= 1'b1;
          else if (op == OP_NOP)
            done_q <= 1'b1;
          else if (op == OP_WR)
            state <= ST_WR_ISSUE;
          else
            state <= ST_RD_ISSUE;
        end
        ST_RD_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (!wait_last) begin
            wait_cnt <= wait_cnt + 3'd1;
          end else if (op_q == OP_RD) begin
            rdata_q <= mem_rdata;
            state   <= ST_FINISH;
          end else if (blk_last) begin
            wdata_q <= avg_val;
            acc     <= '0;
            state   <= ST_WR_ISSUE;
          end else begin
            acc   <= acc_sum;
            state <= ST_RD_ISSUE;
          end
        end
        ST_WR_ISSUE: state <= (op_q == OP_WR) ? ST_FINISH : ST_NEXT;
        ST_NEXT: begin
          if (frame_end) begin
            state <= ST_FINISH;
          end else begin
            step_cnt <= step_cnt + SW'(1);
            state    <= ST_RD_ISSUE;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scale_mem_sequencer.sv
// Bench for scale_mem_sequencer on an 8x4 frame: directed ops push expected memory writes,
// a negedge monitor pops and compares every mem_we cycle.
module tb_scale_mem_sequencer;
  import scale_mem_pkg::*;

  localparam int IMG_W    = 8;
  localparam int IMG_H    = 4;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int RD_LAT   = 2;
  localparam int SRC_BASE = 32;
  localparam int DST_BASE = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        op = '0;
  logic [1:0]        scale = '0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic [DATA_W-1:0] wdata_in = '0;
  logic [DATA_W-1:0] rdata_out;
  logic              busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] rd_p0, rd_p1;
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  bit  sb_off = 1'b0;
  wr_t exp_q[$];

  int dn_addr [8] = '{10, 11, 12, 13, 18, 19, 20, 21};
  int dn_val  [8] = '{32, 34, 36, 38, 48, 50, 52, 54};
  int avg_val [8] = '{15, 38, 40, 42, 52, 54, 56, 58};

  scale_mem_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_LAT(RD_LAT), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .scale     (scale),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .rdata_out (rdata_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory with a two-stage read pipeline: data appears RD_LAT cycles after the address.
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_p0 <= mem[mem_addr];
    rd_p1 <= rd_p0;
  end
  assign mem_rdata = rd_p1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    wr_t e;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (mem_we && !sb_off) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(mem_addr), int'(e.a));
        check("wr_data", int'(mem_wdata), int'(e.d));
      end
    end
  end

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.a = ADDR_W'(a);
    e.d = DATA_W'(d);
    exp_q.push_back(e);
  endtask

  task automatic preload(input int a, input int d);
    @(negedge clock);
    pl_en = 1'b1;
    pl_addr = ADDR_W'(a);
    pl_data = DATA_W'(d);
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [1:0] s,
                        input int a, input int wd, input bit poke, input int exp_cyc);
    int c0, d0;
    bit seen;
    @(negedge clock);
    op = o; scale = s; addr_in = ADDR_W'(a); wdata_in = DATA_W'(wd); start = 1'b1;
    d0 = done_cnt;
    @(negedge clock);
    start = 1'b0;
    c0 = cyc;
    if (poke) begin
      check($sformatf("%s_busy", name), int'(busy), 1);
      repeat (3) @(negedge clock);
      op = OP_WR; addr_in = 8'h63; wdata_in = 8'h55; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 1000 cycles", name);
    end else begin
      check($sformatf("%s_cycles", name), cyc - c0, exp_cyc);
    end
    @(negedge clock);
    check($sformatf("%s_done_pulse_width", name), int'(done), 0);
    check($sformatf("%s_done_count", name), done_cnt - d0, 1);
    check($sformatf("%s_pending_writes", name), exp_q.size(), 0);
  endtask

  task automatic run_err(input string name, input logic [2:0] o, input logic [1:0] s);
    int e0;
    @(negedge clock);
    e0 = err_cnt;
    op = o; scale = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check($sformatf("%s_err", name), int'(err), 1);
    check($sformatf("%s_busy", name), int'(busy), 0);
    check($sformatf("%s_mem_addr", name), int'(mem_addr), 0);
    @(negedge clock);
    check($sformatf("%s_err_width", name), int'(err), 0);
    check($sformatf("%s_err_count", name), err_cnt - e0, 1);
  endtask

  initial begin
    int d0;
    bit seen;
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_rdata", int'(rdata_out), 0);
    reset_n = 1'b1;

    push_wr(5, 8'hA7);
    run_op("wr5", OP_WR, 2'd0, 5, 8'hA7, 1'b0, 1);
    run_op("rd5", OP_RD, 2'd0, 5, 0, 1'b0, RD_LAT + 1);
    check("rd5_rdata", int'(rdata_out), 8'hA7);
    run_op("nop", OP_NOP, 2'd0, 0, 0, 1'b0, 0);

    run_err("op6", 3'd6, 2'd1);
    run_err("nn_up_scale0", OP_NN_UP, 2'd0);
    run_err("blk_scale3", OP_BLK_AVG, 2'd3);

    for (int a = 32; a < 64; a++) preload(a, a);

    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        push_wr(y * IMG_W + x, SRC_BASE + (1 + (y >> 1)) * IMG_W + 2 + (x >> 1));
    run_op("nn_up", OP_NN_UP, 2'd1, 0, 0, 1'b0, 160);
    check("nn_up_dest00", int'(mem[0]), 42);
    check("nn_up_dest33", int'(mem[27]), 51);

    for (int k = 0; k < 8; k++) push_wr(dn_addr[k], dn_val[k]);
    run_op("nn_down_poked", OP_NN_DOWN, 2'd1, 0, 0, 1'b1, 40);
    check("no_write_from_poke", int'(mem[8'h63]), 0);

    preload(32, 10);
    preload(33, 11);
    preload(40, 19);
    preload(41, 20);
    for (int k = 0; k < 8; k++) push_wr(dn_addr[k], avg_val[k]);
    run_op("blk_avg_s1", OP_BLK_AVG, 2'd1, 0, 0, 1'b0, 112);

    for (int a = 32; a < 64; a++) preload(a, 8'hFF);
    push_wr(11, 8'hFF);
    push_wr(12, 8'hFF);
    run_op("blk_avg_s2", OP_BLK_AVG, 2'd2, 0, 0, 1'b0, 100);

    // Abort an NN_UP in the middle of a write cycle.
    sb_off = 1'b1;
    @(negedge clock);
    op = OP_NN_UP; scale = 2'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_we) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("abort_reached_write", int'(seen), 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("abort_mem_we", int'(mem_we), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_mem_addr", int'(mem_addr), 0);
    check("abort_rdata", int'(rdata_out), 0);
    repeat (2) @(negedge clock);
    sb_off = 1'b0;
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", int'(busy), 0);

    push_wr(7, 8'h3C);
    run_op("wr7_after_reset", OP_WR, 2'd0, 7, 8'h3C, 1'b0, 1);
    run_op("rd7_after_reset", OP_RD, 2'd0, 7, 0, 1'b0, RD_LAT + 1);
    check("rd7_rdata", int'(rdata_out), 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
